// File: rtl/w2b_pkg.sv
// Shared types and width helpers for the word-to-byte splitter.
package w2b_pkg;

  localparam int WORD_W_DEF     = 32;
  localparam int BYTE_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } w2b_state_e;

  // Bytes per word.
  function automatic int bpw_of(input int word_w, input int byte_w);
    return word_w / byte_w;
  endfunction

  // Byte counter must hold the value BPW itself, hence the extra bit.
  function automatic int cnt_w_of(input int bpw);
    return $clog2(bpw) + 1;
  endfunction

  // FIFO pointer width; depth is a power of two so pointers wrap naturally.
  function automatic int ptr_w_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/w2b_fifo.sv
// Small synchronous FIFO for the splitter word buffer.
// Pushes while full and pops while empty are ignored.
module w2b_fifo
  import w2b_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PW = ptr_w_of(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             notclk_4f,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Next pointers and occupancy; a simultaneous push and pop leaves the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge notclk_4f) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since the count gates every read.
  always_ff @(posedge notclk_4f) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/word_byte_splitter.sv
// Splits buffered words into an MSB-first byte stream with valid and
// first-byte markers. Consecutive words stream without gaps.
// Optional feature macro: W2B_OVERFLOW_EN adds the sticky overflow_err output.
//
// state | meaning
// IDLE  | no word in flight, outputs zero unless a word is popped this edge
// SHIFT | emitting bytes of the current word; cnt counts bytes already out
module word_byte_splitter
  import w2b_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int BYTE_W     = BYTE_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              notclk_4f,
  input  logic              reset,
  input  logic [WORD_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              first_out
`ifdef W2B_OVERFLOW_EN
  ,
  output logic              overflow_err
`endif
);

  localparam int BPW   = bpw_of(WORD_W, BYTE_W);
  localparam int CNT_W = cnt_w_of(BPW);
  localparam logic [CNT_W-1:0] BPW_C = CNT_W'(BPW);

  w2b_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              first_q, first_d;

  logic [WORD_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;

  w2b_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .notclk_4f (notclk_4f),
    .reset     (reset),
    .push_i    (valid_in),
    .wdata_i   (data_in),
    .pop_i     (fifo_pop),
    .rdata_o   (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Registered occupancy only; a same-edge pop does not reopen the input.
  assign ready_out = !fifo_full;

  // Next state: shift out remaining bytes, else load the next word, else go idle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    data_d   = '0;
    valid_d  = 1'b0;
    first_d  = 1'b0;
    fifo_pop = 1'b0;
    if ((state_q == SHIFT) && (cnt_q < BPW_C)) begin
      data_d  = shreg_q[WORD_W-1 -: BYTE_W];
      valid_d = 1'b1;
      shreg_d = shreg_q << BYTE_W;
      cnt_d   = cnt_q + CNT_W'(1);
    end else if (!fifo_empty) begin
      fifo_pop = 1'b1;
      data_d   = fifo_head[WORD_W-1 -: BYTE_W];
      valid_d  = 1'b1;
      first_d  = 1'b1;
      shreg_d  = fifo_head << BYTE_W;
      cnt_d    = CNT_W'(1);
      state_d  = SHIFT;
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // FSM, shift register and output registers.
  always_ff @(posedge notclk_4f) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      first_q <= first_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign first_out = first_q;

`ifdef W2B_OVERFLOW_EN
  logic ovf_q, ovf_d;

  assign ovf_d = ovf_q | (valid_in & ~ready_out);

  // Sticky refused-word flag, cleared only by reset.
  always_ff @(posedge notclk_4f) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign overflow_err = ovf_q;
`endif

endmodule

// File: tb/tb_word_byte_splitter.sv
module tb_word_byte_splitter;

  logic        notclk_4f;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        first_out;
`ifdef W2B_OVERFLOW_EN
  logic        overflow_err;
`endif

  int checks;
  int failures;

  word_byte_splitter dut (
    .notclk_4f (notclk_4f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .first_out (first_out)
`ifdef W2B_OVERFLOW_EN
    ,
    .overflow_err (overflow_err)
`endif
  );

  initial notclk_4f = 1'b0;
  always #5 notclk_4f = ~notclk_4f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge notclk_4f);
    #1;
  endtask

  logic [31:0] w;
  logic [31:0] packed_w;
  logic [31:0] words3 [4];
  logic [7:0]  exp2 [8];
  logic [8:0]  sb [$];
  logic [8:0]  e;
  int          residual;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_data",  32'(data_out),  32'd0);
    check("rst_first", 32'(first_out), 32'd0);
    check("rst_ready", 32'(ready_out), 32'd1);
`ifdef W2B_OVERFLOW_EN
    check("rst_ovf", 32'(overflow_err), 32'd0);
`endif

    // single word, latency and MSB-first order; bench-side packer aligned to first_out
    w = 32'hA1B2C3D4;
    data_in  = w;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    data_in  = '0;
    check("t1_no_bypass", 32'(valid_out), 32'd0);
    packed_w = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t1_valid", 32'(valid_out), 32'd1);
      check("t1_data",  32'(data_out),  32'(w[31-8*k -: 8]));
      check("t1_first", 32'(first_out), (k == 0) ? 32'd1 : 32'd0);
      packed_w = {packed_w[23:0], data_out};
    end
    check("t1_packed", packed_w, 32'hA1B2C3D4);
    tick();
    check("t1_end_valid", 32'(valid_out), 32'd0);
    check("t1_end_data",  32'(data_out),  32'd0);

    // two words on consecutive cycles give 8 contiguous bytes
    exp2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    data_in  = 32'h11223344;
    valid_in = 1'b1;
    tick();
    data_in  = 32'h55667788;
    tick();
    valid_in = 1'b0;
    data_in  = '0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      check("t2_valid", 32'(valid_out), 32'd1);
      check("t2_data",  32'(data_out),  32'(exp2[k]));
      check("t2_first", 32'(first_out), ((k % 4) == 0) ? 32'd1 : 32'd0);
    end
    tick();
    check("t2_end_valid", 32'(valid_out), 32'd0);

    // four back-to-back words into a depth-2 FIFO: the fourth is refused
    words3 = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
    for (int k = 0; k < 14; k++) begin
      if (k < 4) begin
        valid_in = 1'b1;
        data_in  = words3[k];
        check("t3_ready", 32'(ready_out), (k < 3) ? 32'd1 : 32'd0);
      end else begin
        valid_in = 1'b0;
        data_in  = '0;
      end
      tick();
      if (k >= 1 && k <= 12) begin
        check("t3_valid", 32'(valid_out), 32'd1);
        check("t3_data",  32'(data_out),  32'(k));
        check("t3_first", 32'(first_out), ((k % 4) == 1) ? 32'd1 : 32'd0);
      end else begin
        check("t3_idle_valid", 32'(valid_out), 32'd0);
        check("t3_idle_data",  32'(data_out),  32'd0);
      end
`ifdef W2B_OVERFLOW_EN
      check("t3_ovf", 32'(overflow_err), (k >= 3) ? 32'd1 : 32'd0);
`endif
    end

    // reset after byte B2 with a second word queued
    data_in  = 32'hA1B2C3D4;
    valid_in = 1'b1;
    tick();
    data_in = 32'h11223344;
    tick();
    check("t4_byte0", 32'(data_out), 32'hA1);
    valid_in = 1'b0;
    data_in  = '0;
    tick();
    check("t4_byte1", 32'(data_out), 32'hB2);
    reset = 1'b1;
    tick();
    check("t4_rst_valid", 32'(valid_out), 32'd0);
    check("t4_rst_data",  32'(data_out),  32'd0);
    check("t4_rst_ready", 32'(ready_out), 32'd1);
`ifdef W2B_OVERFLOW_EN
    check("t4_rst_ovf", 32'(overflow_err), 32'd0);
`endif
    reset = 1'b0;
    residual = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (valid_out) residual++;
    end
    check("t4_residual", 32'(residual), 32'd0);

    // random valid_in with a byte scoreboard
    for (int c = 0; c < 1000; c++) begin
      valid_in = ($urandom_range(0, 1) == 1);
      data_in  = $urandom();
      if (valid_in && ready_out) begin
        for (int b = 0; b < 4; b++)
          sb.push_back({(b == 0), data_in[31-8*b -: 8]});
      end
      tick();
      if (sb.size() == 0) begin
        check("rnd_spurious", 32'(valid_out), 32'd0);
      end else if (valid_out) begin
        e = sb.pop_front();
        check("rnd_data",  32'(data_out),  32'(e[7:0]));
        check("rnd_first", 32'(first_out), 32'(e[8]));
      end
      if (!valid_out) check("rnd_zero", 32'(data_out), 32'd0);
    end
    valid_in = 1'b0;
    data_in  = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (sb.size() == 0) begin
        check("drn_spurious", 32'(valid_out), 32'd0);
      end else if (valid_out) begin
        e = sb.pop_front();
        check("drn_data",  32'(data_out),  32'(e[7:0]));
        check("drn_first", 32'(first_out), 32'(e[8]));
      end
    end
    check("drn_left", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/word_byte_splitter.md
Name: word_byte_splitter

Overview:
- Produces the 8-bit byte stream that feeds the 8-to-32 packer, in the 4f domain.
- Accepts 32-bit words with a valid/ready handshake and buffers them in a small synchronous FIFO.
- Emits each word as 4 consecutive bytes, MSB first, with a per-byte valid and a first-byte marker.
- Byte order matches the packer: byte 0 emitted lands in packed bits [31:24].

Parameters:
- WORD_W, 32, input word width; must be a multiple of BYTE_W.
- BYTE_W, 8, output byte width.
- FIFO_DEPTH, 2, word buffer depth; power of 2, ≥2.

Ports:
- notclk_4f  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- data_in  in  WORD_W  word to split.
- valid_in  in  1  data_in is valid this cycle.
- ready_out  out  1  FIFO can accept a word; equals !full, derived from the registered count.
- data_out  out  BYTE_W  current byte, registered.
- valid_out  out  1  data_out is valid, registered.
- first_out  out  1  data_out is byte 0 (bits [WORD_W-1:WORD_W-BYTE_W]) of a word, registered.

Behaviour:
- Reset (reset==1 at an edge): FIFO pointers and count cleared, state IDLE, byte counter 0, data_out=0, valid_out=0, first_out=0. ready_out=1 the cycle after.
- Push: valid_in && ready_out at an edge writes data_in to the FIFO tail. valid_in while full is ignored; the word is dropped and no state changes.
- ready_out does not look ahead to a same-cycle pop: when full, push is refused even if a pop occurs on that edge.
- BPW = WORD_W/BYTE_W (4). States: IDLE, SHIFT.
- IDLE, FIFO non-empty at edge:
  - pop head;
  - data_out <= head[WORD_W-1 -: BYTE_W], valid_out<=1, first_out<=1;
  - shift reg <= head << BYTE_W, cnt<=1, go SHIFT.
- IDLE, FIFO empty: valid_out=0, data_out=0, first_out=0.
- SHIFT, cnt<BPW:
  - data_out <= shreg top byte, valid_out<=1, first_out<=0;
  - shreg <<= BYTE_W, cnt<=cnt+1.
- SHIFT, cnt==BPW (last byte already out):
  - FIFO non-empty: behave exactly as IDLE-pop in the same edge. Gapless, so consecutive words give a continuous byte stream.
  - else: go IDLE, valid_out<=0, data_out<=0.
- Latency: word pushed at edge N into an empty, idle block gives byte 0 at edge N+1, bytes 1..3 at N+2..N+4. No bypass.
- Simultaneous push and pop on one edge: count unchanged, both pointers advance.
- Pointer wrap at FIFO_DEPTH is modulo.
- Throughput: 1 word per BPW cycles sustained. Upstream sees ready_out low while the FIFO is full.
- Zero convention: data_out==0 whenever valid_out==0.
- Reset mid-word: remaining bytes and buffered words are discarded; outputs are zero on the next cycle.

Optional Feature:
- Macro W2B_OVERFLOW_EN.
- Defined:
  - extra output port overflow_err (1 bit), registered, sticky;
  - set on any edge with valid_in==1 && ready_out==0;
  - cleared only by reset.
- Undefined: port absent; dropped words are silent; no extra logic.

Decomposition:
- Package w2b_pkg:
  - BPW localparam derivation;
  - byte counter width $clog2(BPW)+1;
  - state enum {IDLE, SHIFT};
  - FIFO pointer width function.
- Sub-module w2b_fifo:
  - parameterised sync FIFO (WIDTH, DEPTH);
  - push/pop/full/empty/count;
  - same clock and reset.
- Top holds the FSM, the shift register and the output registers.

Test Plan:
- Reset, then 0xA1B2C3D4 pushed at edge N -> data_out A1,B2,C3,D4 at N+1..N+4; first_out only at N+1; valid_out 0 at N+5.
- Words 0x11223344 and 0x55667788 pushed on consecutive cycles -> 8 contiguous valid bytes 11..88, no gap; first_out on 11 and 55.
- Push 4 words back-to-back with FIFO_DEPTH=2:
  - ready_out drops after the 2nd unpopped word;
  - refused words absent from output;
  - with W2B_OVERFLOW_EN, overflow_err=1 and stays 1.
- reset asserted after byte B2 of 0xA1B2C3D4 with a second word queued -> next cycle valid_out=0, data_out=0, FIFO empty; no residual bytes after release.
- Loop output into the 8-to-32 packer clocked at f = 4f/4 and phase-aligned to first_out -> packer output equals 0xA1B2C3D4.
- Random valid_in (50%) for 1000 cycles -> scoreboard: byte stream equals the accepted words split MSB-first, and valid_out never 1 with the FIFO empty in IDLE.
